// File: rtl/mlp_layer_sequencer_if.sv
// Host / multiplier-facing signal bundle of the MLP layer sequencer.
// master = host and multiplier side, slave = the sequencer itself.
interface mlp_layer_sequencer_if #(
    parameter int LAYER_BITS = 2
);
    logic                  go;
    logic                  abort;
    logic [LAYER_BITS:0]   num_layers;
    logic                  cfg_we;
    logic [LAYER_BITS-1:0] cfg_addr;
    logic [7:0]            cfg_bias_a;
    logic [7:0]            cfg_bias_b;
    logic                  mm_done;
    logic                  mm_start;
    logic [LAYER_BITS-1:0] layer_sel;
    logic [7:0]            bias_A;
    logic [7:0]            bias_B;
    logic                  busy;
    logic                  run_done;
    logic                  timeout_err;

    modport master (
        output go, abort, num_layers, cfg_we, cfg_addr,
        output cfg_bias_a, cfg_bias_b, mm_done,
        input  mm_start, layer_sel, bias_A, bias_B,
        input  busy, run_done, timeout_err
    );

    modport slave (
        input  go, abort, num_layers, cfg_we, cfg_addr,
        input  cfg_bias_a, cfg_bias_b, mm_done,
        output mm_start, layer_sel, bias_A, bias_B,
        output busy, run_done, timeout_err
    );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Layer sequencer: one matrix_multiply Start/Done pass per layer with a Start-low gap.
// Optional per-layer watchdog enabled by defining MM_TIMEOUT_EN.
module mlp_layer_sequencer #(
    parameter int MAX_LAYERS     = 4,
    parameter int LAYER_BITS     = 2,
`ifdef MM_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 4096,
`endif
    parameter int GAP_CYCLES     = 2
) (
    input logic                  clk,
    input logic                  resetn,
    mlp_layer_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [LAYER_BITS:0] MAX_N = (LAYER_BITS + 1)'(MAX_LAYERS);
    localparam logic [LAYER_BITS-1:0] LAST_MAX = LAYER_BITS'(MAX_LAYERS - 1);

    state_t                state_q;
    logic [LAYER_BITS-1:0] layer_q;
    logic [LAYER_BITS-1:0] last_q;
    logic [GW-1:0]         gap_q;
    logic                  mm_start_q;
    logic                  busy_q;
    logic                  run_done_q;
    logic [7:0]            bias_a_q;
    logic [7:0]            bias_b_q;
    logic [7:0]            tbl_a_q [MAX_LAYERS];
    logic [7:0]            tbl_b_q [MAX_LAYERS];

    logic [LAYER_BITS-1:0] last_d;
    logic [LAYER_BITS-1:0] layer_d;
    logic                  cfg_wr;
    logic [7:0]            first_a;
    logic [7:0]            first_b;

`ifdef MM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;
`endif

    // A write in the go cycle must reach the layer-0 bias register directly.
    always_comb begin
        last_d  = (bus.num_layers > MAX_N) ? LAST_MAX
                : LAYER_BITS'(bus.num_layers - 1'b1);
        layer_d = layer_q + 1'b1;
        cfg_wr  = bus.cfg_we && (state_q == IDLE);
        first_a = tbl_a_q[0];
        first_b = tbl_b_q[0];
        if (cfg_wr && (bus.cfg_addr == '0)) begin
            first_a = bus.cfg_bias_a;
            first_b = bus.cfg_bias_b;
        end
    end

    // Bias table is deliberately outside reset so it survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            tbl_a_q[bus.cfg_addr] <= bus.cfg_bias_a;
            tbl_b_q[bus.cfg_addr] <= bus.cfg_bias_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            last_q     <= '0;
            gap_q      <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
            bias_a_q   <= '0;
            bias_b_q   <= '0;
`ifdef MM_TIMEOUT_EN
            tmo_q      <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else if (bus.abort) begin
            state_q    <= IDLE;
            layer_q    <= '0;
            gap_q      <= '0;
            mm_start_q <= 1'b0;
            busy_q     <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            run_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        if (bus.num_layers == '0) begin
                            run_done_q <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            last_q     <= last_d;
                            layer_q    <= '0;
                            mm_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            bias_a_q   <= first_a;
                            bias_b_q   <= first_b;
`ifdef MM_TIMEOUT_EN
                            tmo_q      <= '0;
                            tmo_err_q  <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (bus.mm_done) begin
                        mm_start_q <= 1'b0;
                        if (layer_q == last_q) begin
                            state_q    <= FIN;
                            run_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q  <= GAP;
                            gap_q    <= '0;
                            layer_q  <= layer_d;
                            bias_a_q <= tbl_a_q[layer_d];
                            bias_b_q <= tbl_b_q[layer_d];
                        end
                    end
`ifdef MM_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q    <= IDLE;
                        mm_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                        tmo_err_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q    <= RUN;
                        mm_start_q <= 1'b1;
`ifdef MM_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mm_start  = mm_start_q;
    assign bus.layer_sel = layer_q;
    assign bus.bias_A    = bias_a_q;
    assign bus.bias_B    = bias_b_q;
    assign bus.busy      = busy_q;
    assign bus.run_done  = run_done_q;
`ifdef MM_TIMEOUT_EN
    assign bus.timeout_err = tmo_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer; the bench plays host and multiplier.
// Define MM_TIMEOUT_EN to cover the watchdog with a 16-cycle limit.
module tb_mlp_layer_sequencer;
    localparam int LB = 2;
    localparam logic [7:0] K_START = 8'h01;
    localparam logic [7:0] K_DONE  = 8'h02;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.LAYER_BITS(LB)) bus ();

    mlp_layer_sequencer #(
        .MAX_LAYERS(4),
        .LAYER_BITS(LB),
`ifdef MM_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb [$];
    logic [7:0]  m_a [4];
    logic [7:0]  m_b [4];
    logic        st_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input logic [7:0] k, input logic [7:0] l,
                                       input logic [7:0] a, input logic [7:0] b);
        return {k, l, a, b};
    endfunction

    task automatic sb_pop(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, got, 32'h0);
        end else begin
            exp = sb.pop_front();
            chk(tag, got, exp);
        end
    endtask

    // Output monitor: each layer start and each run_done pulse is an event.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.mm_start && !st_prev)
                sb_pop("start_evt", ev(K_START, 8'(bus.layer_sel),
                                       bus.bias_A, bus.bias_B));
            if (bus.run_done)
                sb_pop("done_evt", ev(K_DONE, {6'd0, bus.busy, bus.mm_start},
                                      8'h00, 8'h00));
        end
        st_prev = bus.mm_start;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int adr, input logic [7:0] a, input logic [7:0] b);
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = LB'(adr);
        bus.cfg_bias_a = a;
        bus.cfg_bias_b = b;
        m_a[adr] = a;
        m_b[adr] = b;
        cyc(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic go_run(input int n, input int nstart, input bit exp_done);
        for (int l = 0; l < nstart; l++)
            sb.push_back(ev(K_START, 8'(l), m_a[l], m_b[l]));
        if (exp_done)
            sb.push_back(ev(K_DONE, 8'h00, 8'h00, 8'h00));
        bus.num_layers = 3'(n);
        bus.go = 1'b1;
        cyc(1);
        bus.go = 1'b0;
    endtask

    task automatic serve(input int hold, output int lows, output bit fin);
        int w;
        w = 0;
        while (!bus.mm_start && w < 20) begin
            w++;
            cyc(1);
        end
        chk("start_seen", 32'(bus.mm_start), 32'd1);
        cyc(hold);
        bus.mm_done = 1'b1;
        cyc(1);
        bus.mm_done = 1'b0;
        lows = 0;
        fin  = 1'b0;
        while (lows < 20) begin
            if (bus.run_done) begin
                fin = 1'b1;
                break;
            end
            if (bus.mm_start) break;
            lows++;
            cyc(1);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.busy, bus.run_done, bus.mm_start, bus.timeout_err,
                    bus.layer_sel, bus.bias_A, bus.bias_B});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   lows;
        bit   fin;
        logic hi;
        int   cnt;
        bus.go = 1'b0;
        bus.abort = 1'b0;
        bus.num_layers = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_bias_a = '0;
        bus.cfg_bias_b = '0;
        bus.mm_done = 1'b0;
        resetn = 1'b0;
        cyc(3);
        chk("rst_outs", outs(), 32'h0);
        resetn = 1'b1;
        cyc(1);

        // T1: two-layer run
        cfg(0, 8'h10, 8'h20);
        cfg(1, 8'h30, 8'h40);
        go_run(2, 2, 1'b1);
        chk("t1_latency", 32'(bus.mm_start), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_bias_hold", 32'({bus.bias_A, bus.bias_B}), 32'h1020);
            cyc(1);
        end
        serve(0, lows, fin);
        chk("t1_gap", lows, 2);
        chk("t1_fin0", 32'(fin), 32'd0);
        chk("t1_layer1", 32'(bus.layer_sel), 32'd1);
        chk("t1_bias1", 32'({bus.bias_A, bus.bias_B}), 32'h3040);
        serve(2, lows, fin);
        chk("t1_fin1", 32'(fin), 32'd1);
        chk("t1_busy_off", 32'(bus.busy), 32'd0);
        cyc(1);
        chk("t1_pulse_len", 32'(bus.run_done), 32'd0);

        // T2: zero layers
        go_run(0, 0, 1'b1);
        chk("t2_done", 32'(bus.run_done), 32'd1);
        hi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hi = hi | bus.mm_start | bus.busy;
            cyc(1);
        end
        chk("t2_idle", 32'(hi), 32'd0);

        // T3: abort in layer 1 of 3, with mm_done in the same cycle
        cfg(2, 8'h50, 8'h60);
        go_run(3, 2, 1'b0);
        serve(1, lows, fin);
        chk("t3_gap", lows, 2);
        cyc(2);
        bus.abort = 1'b1;
        bus.mm_done = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        bus.mm_done = 1'b0;
        chk("t3_abort", 32'({bus.mm_start, bus.busy, bus.run_done}), 32'd0);
        hi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hi = hi | bus.mm_start | bus.busy | bus.run_done;
            cyc(1);
        end
        chk("t3_quiet", 32'(hi), 32'd0);
        go_run(1, 1, 1'b1);
        chk("t3_restart_layer", 32'(bus.layer_sel), 32'd0);
        serve(0, lows, fin);
        chk("t3_fin", 32'(fin), 32'd1);
        cyc(1);

        // T4: go and cfg_we while busy are ignored
        go_run(2, 2, 1'b1);
        bus.go = 1'b1;
        bus.num_layers = 3'd4;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_bias_a = 8'hAA;
        bus.cfg_bias_b = 8'hBB;
        cyc(1);
        bus.go = 1'b0;
        bus.cfg_we = 1'b0;
        chk("t4_no_restart", 32'({bus.layer_sel, bus.mm_start, bus.busy}), 32'b0011);
        chk("t4_bias", 32'({bus.bias_A, bus.bias_B}), 32'h1020);
        serve(0, lows, fin);
        serve(0, lows, fin);
        chk("t4_fin", 32'(fin), 32'd1);
        cyc(1);
        go_run(1, 1, 1'b1);
        serve(0, lows, fin);
        chk("t4_readback_fin", 32'(fin), 32'd1);
        cyc(1);

        // cfg_we and go together: the new bias is used
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_bias_a = 8'h11;
        bus.cfg_bias_b = 8'h22;
        m_a[0] = 8'h11;
        m_b[0] = 8'h22;
        go_run(1, 1, 1'b1);
        bus.cfg_we = 1'b0;
        chk("wr_go_bias", 32'({bus.bias_A, bus.bias_B}), 32'h1122);
        serve(0, lows, fin);
        cyc(1);

        // num_layers above the limit runs the full table
        cfg(3, 8'h70, 8'h80);
        go_run(7, 4, 1'b1);
        for (int l = 0; l < 4; l++) begin
            serve(0, lows, fin);
            chk("clamp_fin", 32'(fin), 32'(l == 3));
            if (l < 3) chk("clamp_gap", lows, 2);
        end
        cyc(1);

        // T5: reset during the gap keeps the bias table
        go_run(3, 1, 1'b0);
        bus.mm_done = 1'b1;
        cyc(1);
        bus.mm_done = 1'b0;
        chk("t5_in_gap", 32'({bus.mm_start, bus.busy, bus.layer_sel}), 32'b0101);
        resetn = 1'b0;
        cyc(2);
        chk("t5_rst_outs", outs(), 32'h0);
        resetn = 1'b1;
        cyc(1);
        go_run(2, 2, 1'b1);
        serve(0, lows, fin);
        serve(0, lows, fin);
        chk("t5_fin", 32'(fin), 32'd1);
        cyc(1);

`ifdef MM_TIMEOUT_EN
        // T6: watchdog with mm_done never arriving
        go_run(2, 1, 1'b0);
        cnt = 0;
        while (bus.mm_start && cnt < 40) begin
            cnt++;
            cyc(1);
        end
        chk("t6_run_len", cnt, 16);
        chk("t6_err", 32'({bus.timeout_err, bus.busy, bus.run_done, bus.mm_start}),
            32'b1000);
        cyc(3);
        chk("t6_sticky", 32'(bus.timeout_err), 32'd1);
        go_run(1, 1, 1'b1);
        chk("t6_clear", 32'(bus.timeout_err), 32'd0);
        serve(0, lows, fin);
        chk("t6_fin", 32'(fin), 32'd1);
        cyc(1);
`else
        // Without the watchdog a long layer just waits
        go_run(1, 1, 1'b1);
        serve(40, lows, fin);
        chk("long_fin", 32'(fin), 32'd1);
        chk("no_tmo", 32'(bus.timeout_err), 32'd0);
        cnt = 0;
        cyc(1);
`endif

        cyc(2);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
